// File: rtl/parking_gate_ctrl.sv
// Entry-barrier controller: per-lane barrier FSMs, round-robin grant arbiter and exit merger for the parking counter.
// Latency: req rise to gate_open/car_entered is 2 cycles minimum; exit_pulse to car_exited is 2 cycles minimum.
// Backpressure: one commit (exit, cancel or grant) per free slot; lanes wait in REQ/CANCEL and exits wait in pending.
// Ports: req/req_uni/passed per lane in; exit_pulse/exit_uni and the counter space flags in;
//        car_entered/car_exited (+class) pulses to the counter; gate_open/reject/busy per lane; timeout_cnt rollbacks.
module parking_gate_ctrl #(
  parameter int NUM_LANES    = 4,
  parameter int OPEN_TIMEOUT = 20,
  parameter int CLOSE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] req,
  input  logic [NUM_LANES-1:0] req_uni,
  input  logic [NUM_LANES-1:0] passed,
  input  logic                 exit_pulse,
  input  logic                 exit_uni,
  input  logic                 uni_is_vacated_space,
  input  logic                 is_vacated_space,
  output logic                 car_entered,
  output logic                 is_uni_car_entered,
  output logic                 car_exited,
  output logic                 is_uni_car_exited,
  output logic [NUM_LANES-1:0] gate_open,
  output logic [NUM_LANES-1:0] reject,
  output logic [NUM_LANES-1:0] busy,
  output logic [7:0]           timeout_cnt
);

  localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int TW = $clog2(OPEN_TIMEOUT);
  localparam int CW = (CLOSE_CYCLES > 1) ? $clog2(CLOSE_CYCLES) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(OPEN_TIMEOUT - 1);
  localparam logic [CW-1:0] CLOSE_LAST = CW'(CLOSE_CYCLES - 1);
  localparam logic [PW-1:0] LAST_LANE  = PW'(NUM_LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_OPEN,
    S_CANCEL,
    S_CLOSING
  } lane_state_t;

  lane_state_t          state_q [NUM_LANES];
  lane_state_t          state_d [NUM_LANES];
  logic [TW-1:0]        timer_q [NUM_LANES];
  logic [TW-1:0]        timer_d [NUM_LANES];
  logic [CW-1:0]        close_q [NUM_LANES];
  logic [CW-1:0]        close_d [NUM_LANES];
  logic [NUM_LANES-1:0] uni_q;
  logic [NUM_LANES-1:0] uni_d;

  logic [PW-1:0]        rr_ptr;
  logic                 pending_exit;
  logic                 pending_uni;

  logic                 slot_free;
  logic [NUM_LANES-1:0] class_ok;
  logic [NUM_LANES-1:0] eligible;
  logic [NUM_LANES-1:0] cancel_vec;
  logic                 do_exit;
  logic                 do_cancel;
  logic                 do_grant;
  logic [PW-1:0]        cancel_idx;
  logic [PW-1:0]        grant_idx;

  // Lowest set index; used for cancel service order.
  function automatic logic [PW-1:0] lowest_set(input logic [NUM_LANES-1:0] v);
    logic [PW-1:0] r;
    r = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (v[i]) r = PW'(i);
    end
    return r;
  endfunction

  // First set index at or after ptr, wrapping around the lane count.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_LANES-1:0] v,
                                            input logic [PW-1:0]        ptr);
    logic [PW-1:0] r;
    logic [PW-1:0] idx;
    logic          found;
    int            idx_i;
    r     = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx_i = int'(ptr) + k;
      if (idx_i >= NUM_LANES) idx_i = idx_i - NUM_LANES;
      idx = PW'(idx_i);
      if (!found && v[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Commit arbitration. A slot is free only when neither counter pulse is
  // high, so the counter's space flags already reflect the last commit.
  always_comb begin
    slot_free  = !car_entered && !car_exited;
    class_ok   = '0;
    eligible   = '0;
    cancel_vec = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      class_ok[i]   = uni_q[i] ? uni_is_vacated_space : is_vacated_space;
      // A lane whose car has driven off (req dropped) is not granted.
      eligible[i]   = (state_q[i] == S_REQ) && class_ok[i] && req[i];
      cancel_vec[i] = (state_q[i] == S_CANCEL);
    end
    cancel_idx = lowest_set(cancel_vec);
    grant_idx  = rr_pick(eligible, rr_ptr);
    do_exit    = slot_free && pending_exit;
    do_cancel  = slot_free && !pending_exit && (|cancel_vec);
    do_grant   = slot_free && !pending_exit && !(|cancel_vec) && (|eligible);
  end

  // Per-lane next-state and lane-status outputs.
  always_comb begin
    gate_open = '0;
    reject    = '0;
    busy      = '0;
    uni_d     = uni_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      close_d[i] = close_q[i];
      busy[i]    = (state_q[i] != S_IDLE);
      case (state_q[i])
        S_IDLE: begin
          if (req[i]) begin
            state_d[i] = S_REQ;
            uni_d[i]   = req_uni[i];
          end
        end
        S_REQ: begin
          reject[i] = !class_ok[i];
          if (do_grant && (grant_idx == PW'(i))) begin
            state_d[i] = S_OPEN;
            timer_d[i] = '0;
          end else if (!req[i]) begin
            state_d[i] = S_IDLE;
          end
        end
        S_OPEN: begin
          gate_open[i] = 1'b1;
          if (passed[i]) begin
            state_d[i] = S_CLOSING;
            close_d[i] = '0;
          end else if (timer_q[i] == TIMER_LAST) begin
            state_d[i] = S_CANCEL;
          end else begin
            timer_d[i] = timer_q[i] + 1'b1;
          end
        end
        S_CANCEL: begin
          // Barrier stays raised until the rollback is committed.
          gate_open[i] = 1'b1;
          if (do_cancel && (cancel_idx == PW'(i))) begin
            state_d[i] = S_CLOSING;
            close_d[i] = '0;
          end
        end
        S_CLOSING: begin
          if (close_q[i] == CLOSE_LAST) begin
            state_d[i] = S_IDLE;
          end else begin
            close_d[i] = close_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= S_IDLE;
        timer_q[i] <= '0;
        close_q[i] <= '0;
      end
      uni_q              <= '0;
      rr_ptr             <= '0;
      pending_exit       <= 1'b0;
      pending_uni        <= 1'b0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      timeout_cnt        <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        close_q[i] <= close_d[i];
      end
      uni_q <= uni_d;

      // A pulse seen while an exit is still pending is dropped.
      if (do_exit) begin
        pending_exit <= 1'b0;
      end else if (exit_pulse && !pending_exit) begin
        pending_exit <= 1'b1;
        pending_uni  <= exit_uni;
      end

      car_entered        <= do_grant;
      is_uni_car_entered <= do_grant && uni_q[grant_idx];
      car_exited         <= do_exit || do_cancel;
      is_uni_car_exited  <= do_exit ? pending_uni : (do_cancel && uni_q[cancel_idx]);

      if (do_grant) begin
        rr_ptr <= (grant_idx == LAST_LANE) ? '0 : grant_idx + 1'b1;
      end

      if (do_cancel && (timeout_cnt != 8'hFF)) begin
        timeout_cnt <= timeout_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
module tb_parking_gate_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] req_uni;
  logic [3:0] passed;
  logic       exit_pulse;
  logic       exit_uni;
  logic       uni_is_vacated_space;
  logic       is_vacated_space;
  logic       car_entered;
  logic       is_uni_car_entered;
  logic       car_exited;
  logic       is_uni_car_exited;
  logic [3:0] gate_open;
  logic [3:0] reject;
  logic [3:0] busy;
  logic [7:0] timeout_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       is_exit;
    logic       uni;
    logic [3:0] mask;
  } ev_t;

  ev_t  exp_q[$];
  logic [3:0] prev_gate;
  logic       prev_ent;

  parking_gate_ctrl #(
    .NUM_LANES   (4),
    .OPEN_TIMEOUT(20),
    .CLOSE_CYCLES(3)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .req                 (req),
    .req_uni             (req_uni),
    .passed              (passed),
    .exit_pulse          (exit_pulse),
    .exit_uni            (exit_uni),
    .uni_is_vacated_space(uni_is_vacated_space),
    .is_vacated_space    (is_vacated_space),
    .car_entered         (car_entered),
    .is_uni_car_entered  (is_uni_car_entered),
    .car_exited          (car_exited),
    .is_uni_car_exited   (is_uni_car_exited),
    .gate_open           (gate_open),
    .reject              (reject),
    .busy                (busy),
    .timeout_cnt         (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every counter pulse must match the next expected commit.
  always @(negedge clk) begin
    if (reset) begin
      if (car_entered || car_exited) begin
        checks++;
        if (car_entered && car_exited) begin
          errors++;
          $display("FAIL overlap: car_entered=1 car_exited=1 required not both");
        end
        checks++;
        if (car_entered && prev_ent) begin
          errors++;
          $display("FAIL enter_spacing: car_entered high two cycles running");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL commit_unexpected: entered=%b exited=%b with nothing expected",
                   car_entered, car_exited);
        end else begin
          ev_t ev;
          ev = exp_q.pop_front();
          if (ev.is_exit) begin
            if (!car_exited || car_exited_uni_mismatch(ev.uni)) begin
              errors++;
              $display("FAIL commit_exit: exited=%b uni=%b required exited=1 uni=%b",
                       car_exited, is_uni_car_exited, ev.uni);
            end
          end else begin
            if (!car_entered || (is_uni_car_entered !== ev.uni) ||
                ((gate_open & ~prev_gate) !== ev.mask)) begin
              errors++;
              $display("FAIL commit_enter: entered=%b uni=%b new_gate=%b required 1 %b %b",
                       car_entered, is_uni_car_entered, gate_open & ~prev_gate, ev.uni, ev.mask);
            end
          end
        end
      end
    end
    prev_gate = gate_open;
    prev_ent  = car_entered;
  end

  function automatic logic car_exited_uni_mismatch(input logic want);
    return (is_uni_car_exited !== want);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req = '0; req_uni = '0; passed = '0;
    exit_pulse = 1'b0; exit_uni = 1'b0;
    tick(2);
    exp_q.delete();
    reset = 1'b1;
    tick();
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d expected commits never seen, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = '0; req_uni = '0; passed = '0;
    exit_pulse = 1'b0; exit_uni = 1'b0;
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;
    tick(2);
    checks++;
    if ({car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
         gate_open, reject, busy, timeout_cnt} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: ent=%b ex=%b gate=%b rej=%b busy=%b tcnt=%0d required all 0",
               car_entered, car_exited, gate_open, reject, busy, timeout_cnt);
    end
    checks++;
    if (dut.rr_ptr !== 2'd0) begin
      errors++;
      $display("FAIL reset_rr_ptr: got %0d required 0", dut.rr_ptr);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_lane();
    apply_reset();
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;
    req[0] = 1'b1; req_uni[0] = 1'b1;
    exp_q.push_back('{is_exit: 1'b0, uni: 1'b1, mask: 4'b0001});
    tick();
    checks++;
    if (busy[0] !== 1'b1 || gate_open[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_req: busy=%b gate=%b required busy=1 gate=0", busy[0], gate_open[0]);
    end
    tick();
    checks++;
    if (car_entered !== 1'b1 || gate_open[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: ent=%b gate=%b required 1 1", car_entered, gate_open[0]);
    end
    req[0] = 1'b0; passed[0] = 1'b1;
    tick();
    passed[0] = 1'b0;
    checks++;
    if (gate_open[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_closing: gate=%b busy=%b required gate=0 busy=1", gate_open[0], busy[0]);
    end
    tick(2);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_close_hold: busy=%b required 1", busy[0]);
    end
    tick();
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b required 0", busy[0]);
    end
    check_queue_empty("single");
  endtask

  task automatic test_round_robin();
    int granted;
    int grant_cyc[4];
    apply_reset();
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;
    req = 4'b1111; req_uni = 4'b0000;
    for (int l = 0; l < 4; l++) begin
      ev_t ev;
      ev.is_exit = 1'b0; ev.uni = 1'b0; ev.mask = 4'b0001 << l;
      exp_q.push_back(ev);
    end
    granted = 0;
    for (int c = 1; c <= 16 && granted < 4; c++) begin
      tick();
      if (car_entered) begin
        grant_cyc[granted] = c;
        granted++;
      end
      passed = gate_open;
      req    = req & ~gate_open;
    end
    passed = '0;
    checks++;
    if (granted != 4) begin
      errors++;
      $display("FAIL rr_count: %0d grants required 4", granted);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grant_cyc[k] != 2 + 2 * k) begin
          errors++;
          $display("FAIL rr_timing: grant %0d at cycle %0d required %0d", k, grant_cyc[k], 2 + 2 * k);
        end
      end
    end
    tick(5);
    checks++;
    if (dut.rr_ptr !== 2'd0) begin
      errors++;
      $display("FAIL rr_ptr_end: got %0d required 0", dut.rr_ptr);
    end
    check_queue_empty("rr");
  endtask

  task automatic test_reject();
    int n;
    apply_reset();
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0;
    req[2] = 1'b1; req_uni[2] = 1'b0;
    tick(4);
    checks++;
    if (reject[2] !== 1'b1 || gate_open[2] !== 1'b0 || busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL reject_full: rej=%b gate=%b busy=%b required 1 0 1", reject[2], gate_open[2], busy[2]);
    end
    is_vacated_space = 1'b1;
    exp_q.push_back('{is_exit: 1'b0, uni: 1'b0, mask: 4'b0100});
    #1;
    checks++;
    if (reject[2] !== 1'b0) begin
      errors++;
      $display("FAIL reject_clear: rej=%b required 0", reject[2]);
    end
    n = 0;
    while (!gate_open[2] && n < 2) begin
      tick();
      n++;
    end
    checks++;
    if (gate_open[2] !== 1'b1) begin
      errors++;
      $display("FAIL reject_grant: gate=%b after %0d cycles required 1", gate_open[2], n);
    end
    req[2] = 1'b0; passed[2] = 1'b1;
    tick();
    passed[2] = 1'b0;
    tick(4);
    check_queue_empty("reject");
  endtask

  task automatic test_timeout();
    int n;
    logic gate_in_cancel;
    apply_reset();
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;
    req[1] = 1'b1; req_uni[1] = 1'b1;
    exp_q.push_back('{is_exit: 1'b0, uni: 1'b1, mask: 4'b0010});
    exp_q.push_back('{is_exit: 1'b1, uni: 1'b1, mask: 4'b0000});
    tick(2);
    checks++;
    if (gate_open[1] !== 1'b1) begin
      errors++;
      $display("FAIL timeout_open: gate=%b required 1", gate_open[1]);
    end
    req[1] = 1'b0;
    n = 0;
    gate_in_cancel = 1'b0;
    while (!car_exited && n < 40) begin
      tick();
      n++;
      if (n == 20) gate_in_cancel = gate_open[1];
    end
    checks++;
    if (n != 21) begin
      errors++;
      $display("FAIL timeout_latency: car_exited after %0d cycles required 21", n);
    end
    checks++;
    if (gate_in_cancel !== 1'b1) begin
      errors++;
      $display("FAIL timeout_cancel_gate: gate=%b required 1", gate_in_cancel);
    end
    checks++;
    if (timeout_cnt !== 8'd1 || gate_open[1] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_commit: tcnt=%0d gate=%b required 1 0", timeout_cnt, gate_open[1]);
    end
    tick(2);
    checks++;
    if (busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL timeout_closing: busy=%b required 1", busy[1]);
    end
    tick();
    checks++;
    if (busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: busy=%b required 0", busy[1]);
    end
    check_queue_empty("timeout");
  endtask

  task automatic test_exit_priority();
    apply_reset();
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;
    exit_pulse = 1'b1; exit_uni = 1'b1;
    req[3] = 1'b1; req_uni[3] = 1'b0;
    exp_q.push_back('{is_exit: 1'b1, uni: 1'b1, mask: 4'b0000});
    exp_q.push_back('{is_exit: 1'b0, uni: 1'b0, mask: 4'b1000});
    tick();
    exit_pulse = 1'b0; exit_uni = 1'b0;
    checks++;
    if (car_exited !== 1'b0 || car_entered !== 1'b0 || busy[3] !== 1'b1) begin
      errors++;
      $display("FAIL exitpri_wait: ex=%b ent=%b busy=%b required 0 0 1", car_exited, car_entered, busy[3]);
    end
    tick();
    checks++;
    if (car_exited !== 1'b1 || car_entered !== 1'b0) begin
      errors++;
      $display("FAIL exitpri_exit: ex=%b ent=%b required 1 0", car_exited, car_entered);
    end
    tick(2);
    checks++;
    if (car_entered !== 1'b1 || gate_open[3] !== 1'b1) begin
      errors++;
      $display("FAIL exitpri_enter: ent=%b gate=%b required 1 1", car_entered, gate_open[3]);
    end
    req[3] = 1'b0; passed[3] = 1'b1;
    tick();
    passed[3] = 1'b0;
    tick(4);
    check_queue_empty("exitpri");
  endtask

  task automatic test_reset_midop();
    int exits;
    apply_reset();
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;
    req[0] = 1'b1; req_uni[0] = 1'b0;
    exp_q.push_back('{is_exit: 1'b0, uni: 1'b0, mask: 4'b0001});
    tick(2);
    req[0] = 1'b0;
    exit_pulse = 1'b1; exit_uni = 1'b1;
    tick();
    exit_pulse = 1'b0; exit_uni = 1'b0;
    checks++;
    if (gate_open[0] !== 1'b1 || dut.pending_exit !== 1'b1) begin
      errors++;
      $display("FAIL midop_setup: gate=%b pending=%b required 1 1", gate_open[0], dut.pending_exit);
    end
    check_queue_empty("midop");
    reset = 1'b0;
    #1;
    checks++;
    if ({car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
         gate_open, reject, busy, timeout_cnt} !== 24'h0) begin
      errors++;
      $display("FAIL midop_reset: ent=%b ex=%b gate=%b busy=%b required all 0",
               car_entered, car_exited, gate_open, busy);
    end
    tick(2);
    reset = 1'b1;
    exits = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (car_exited) exits++;
    end
    checks++;
    if (exits != 0 || busy !== 4'b0000) begin
      errors++;
      $display("FAIL midop_after: exits=%0d busy=%b required 0 0000", exits, busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    prev_gate = '0;
    prev_ent  = 1'b0;
    test_reset();
    test_single_lane();
    test_round_robin();
    test_reject();
    test_timeout();
    test_exit_priority();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Entry-barrier controller and arbiter for the campus parking counter.
- Owns NUM_LANES entry barriers. Round-robin arbitrates lane requests against the counter's per-class space flags and drives the counter's single enter/exit event ports.
- Reserves a space at grant time and rolls the reservation back if the car never passes. Merges real exit-loop events into the same exit port.

Parameters:
NUM_LANES, 4, number of entry lanes (2..8)
OPEN_TIMEOUT, 20, cycles a barrier stays open waiting for passed before rollback (>=2)
CLOSE_CYCLES, 3, cycles barrier spends closing before lane is free (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req  in  NUM_LANES  car waiting at lane i (level)
req_uni  in  NUM_LANES  car at lane i is university-tagged; sampled on IDLE->REQ
passed  in  NUM_LANES  loop sensor: car cleared barrier i (1-cycle pulse)
exit_pulse  in  1  exit loop: a car left the lot (1-cycle pulse)
exit_uni  in  1  class of exiting car, valid with exit_pulse
uni_is_vacated_space  in  1  counter: uni class has space
is_vacated_space  in  1  counter: public class has space
car_entered  out  1  to counter, registered 1-cycle pulse
is_uni_car_entered  out  1  class of car_entered
car_exited  out  1  to counter, registered 1-cycle pulse
is_uni_car_exited  out  1  class of car_exited
gate_open  out  NUM_LANES  barrier i raised
reject  out  NUM_LANES  lane i in REQ and its class full (level)
busy  out  NUM_LANES  lane i not IDLE
timeout_cnt  out  8  rollback count, saturates at 255

Behaviour:
- Reset (async, reset=0):
  - All lanes go to IDLE.
  - All outputs are 0, timeout_cnt=0, rr_ptr=0.
  - The pending-exit register is cleared.
  - Reset mid-operation drops any reservation; the counter is reset by the same net.
- Per-lane FSM, states IDLE, REQ, OPEN, CANCEL, CLOSING:
  - IDLE: req[i]=1 -> REQ at the next edge; latch uni_i=req_uni[i].
  - REQ:
    - req[i]=0 -> IDLE.
    - On grant -> OPEN, timer=0.
    - reject[i] = the class-space flag for uni_i is 0.
  - OPEN:
    - gate_open=1; timer increments each cycle.
    - passed[i]=1 -> CLOSING.
    - timer==OPEN_TIMEOUT-1 with no passed -> CANCEL.
    - passed wins over timeout in the same cycle.
  - CANCEL: gate_open=1; wait for a commit slot; on cancel commit -> CLOSING and timeout_cnt++ (saturating).
  - CLOSING: gate_open=0 for CLOSE_CYCLES cycles -> IDLE.
  - passed outside OPEN is ignored.
- Commit slot:
  - A commit (grant, cancel or exit forward) may be decided only in a cycle where car_entered=0 and car_exited=0.
  - At most one commit per slot, so at most one commit every 2 cycles. This guarantees the counter's space flags are current when sampled.
- Commit priority: pending exit > cancel > grant.
  - The counter lets exit override a simultaneous enter, so enter and exit are never issued in the same cycle.
- Exit forward:
  - exit_pulse sets pending_exit and latches exit_uni.
  - A commit emits car_exited=1, is_uni_car_exited=latched class next cycle, and clears pending.
  - The environment guarantees exit_pulse spacing >=4 cycles.
  - An exit_pulse arriving while pending is already set is dropped.
- Cancel:
  - Lowest-index lane in CANCEL is served first.
  - Emits car_exited=1, is_uni_car_exited=uni_i next cycle.
- Grant:
  - Eligible lanes = in REQ with their class flag = 1.
  - Pick the first eligible index at or after rr_ptr, cyclic.
  - Next cycle: car_entered=1, is_uni_car_entered=uni_i; lane enters OPEN.
  - rr_ptr <= (granted+1) mod NUM_LANES.
  - If no lane is eligible, rr_ptr is unchanged.
- Latency:
  - req rise to gate_open is 2 cycles minimum (IDLE->REQ, grant).
  - Each further contending lane adds >=2 cycles.
- Class flags are used only in REQ/grant; a full class never blocks cancel or exit forwarding.

Test Plan:
- Reset, then req[0]=1, req_uni[0]=1, uni flag=1 -> busy[0] next edge; car_entered=1, is_uni_car_entered=1 and gate_open[0]=1 one cycle later; passed[0] -> gate_open[0]=0, busy[0] low 3 cycles after.
- req=4'b1111 same cycle, all flags=1, rr_ptr=0 -> grants in order 0,1,2,3 on every other cycle; car_entered never high two cycles running; rr_ptr ends 0.
- Lane 2 public, is_vacated_space=0 -> reject[2]=1, no grant; flag rises -> grant within 2 cycles, reject[2]=0.
- Lane 1 granted, no passed for 20 cycles -> CANCEL; car_exited=1 with is_uni_car_exited=uni_1; timeout_cnt=1; gate closes after 3 cycles.
- exit_pulse with uni, same cycle lane 3 ready to grant -> car_exited issued first, car_entered 2 cycles later; never both high in one cycle.
- Assert reset while lane 0 OPEN and pending exit set -> all outputs 0 immediately, no car_exited emitted after release.
